// File: rtl/rbz_layer_compositor.sv
// rbz_layer_compositor
//   Three-stage pixel compositor. It picks one colour per pixel from NUM_LAYERS
//   prioritised overlay layers (layer 0 wins), or from a split-screen
//   background, and then optionally reduces the colour depth with 2x2 ordered
//   dither. Syncs and positions go through the same three registers as the
//   colour, so every output stays aligned.
//   The layer mask, background colours and split column are held in shadow
//   registers. They are copied to the active set only on a frame-end strobe.
// Ports
//   clk, reset          pixel clock, synchronous active-high reset
//   i_hpos/i_vpos       beam position from vga_sync
//   i_hsync/i_vsync     active-high syncs
//   i_visible           pixel lies inside the visible area
//   i_layer_en/_rgb     per-layer presence flags and packed {R,G,B} colours
//   i_cfg_*             new mask/backgrounds/split, captured on i_cfg_valid
//   i_frame_end         strobe that applies the pending shadow config
//   o_hsync_n/o_vsync_n delayed, inverted syncs
//   o_rgb               composited (depth-reduced) colour
//   o_hpos/o_vpos       positions aligned with o_rgb
//   o_cfg_pending       shadow holds config not yet applied
module rbz_layer_compositor #(
    parameter int NUM_LAYERS  = 4,
    parameter int CH_BITS     = 2,
    parameter int OUT_CH_BITS = 2,
    parameter int DITHER      = 0,
    parameter int H_VIEW      = 640
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [9:0]                        i_hpos,
    input  logic [9:0]                        i_vpos,
    input  logic                              i_hsync,
    input  logic                              i_vsync,
    input  logic                              i_visible,
    input  logic [NUM_LAYERS-1:0]             i_layer_en,
    input  logic [NUM_LAYERS*3*CH_BITS-1:0]   i_layer_rgb,
    input  logic [NUM_LAYERS-1:0]             i_cfg_mask,
    input  logic [3*CH_BITS-1:0]              i_cfg_bg_left,
    input  logic [3*CH_BITS-1:0]              i_cfg_bg_right,
    input  logic [9:0]                        i_cfg_split,
    input  logic                              i_cfg_valid,
    input  logic                              i_frame_end,
    output logic                              o_hsync_n,
    output logic                              o_vsync_n,
    output logic [3*OUT_CH_BITS-1:0]          o_rgb,
    output logic [9:0]                        o_hpos,
    output logic [9:0]                        o_vpos,
    output logic                              o_cfg_pending
);

    localparam int CW  = 3 * CH_BITS;
    localparam int OW  = 3 * OUT_CH_BITS;
    localparam int D   = CH_BITS - OUT_CH_BITS;
    localparam int DS  = (D > 0) ? D : 0;
    localparam int TSH = (D >= 2) ? D - 2 : 0;

    // Default backgrounds: half-scale grey on the left, quarter-scale on the right.
    localparam logic [CH_BITS-1:0] BG_CH   = CH_BITS'(1) << (CH_BITS - 1);
    localparam logic [CH_BITS-1:0] BG_CH_R = BG_CH >> 1;
    localparam logic [CW-1:0]      BG_L    = {3{BG_CH}};
    localparam logic [CW-1:0]      BG_R    = {3{BG_CH_R}};
    localparam logic [9:0]         SPLIT0  = 10'(H_VIEW / 2);

    generate
        if (OUT_CH_BITS > CH_BITS) begin : g_bad_width
            $error("rbz_layer_compositor: OUT_CH_BITS must not exceed CH_BITS");
        end
        if (DITHER != 0 && D < 2) begin : g_bad_dither
            $error("rbz_layer_compositor: DITHER needs CH_BITS-OUT_CH_BITS >= 2");
        end
    endgenerate

    // ---------------- configuration (shadow / active) ----------------
    logic [NUM_LAYERS-1:0] act_mask, sh_mask;
    logic [CW-1:0]         act_bg_left, act_bg_right, sh_bg_left, sh_bg_right;
    logic [9:0]            act_split, sh_split;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_mask      <= '1;
            act_bg_left   <= BG_L;
            act_bg_right  <= BG_R;
            act_split     <= SPLIT0;
            sh_mask       <= '1;
            sh_bg_left    <= BG_L;
            sh_bg_right   <= BG_R;
            sh_split      <= SPLIT0;
            o_cfg_pending <= 1'b0;
        end else if (i_cfg_valid) begin
            sh_mask     <= i_cfg_mask;
            sh_bg_left  <= i_cfg_bg_left;
            sh_bg_right <= i_cfg_bg_right;
            sh_split    <= i_cfg_split;
            // A strobe coinciding with frame end skips the shadow wait.
            if (i_frame_end) begin
                act_mask      <= i_cfg_mask;
                act_bg_left   <= i_cfg_bg_left;
                act_bg_right  <= i_cfg_bg_right;
                act_split     <= i_cfg_split;
                o_cfg_pending <= 1'b0;
            end else begin
                o_cfg_pending <= 1'b1;
            end
        end else if (i_frame_end && o_cfg_pending) begin
            act_mask      <= sh_mask;
            act_bg_left   <= sh_bg_left;
            act_bg_right  <= sh_bg_right;
            act_split     <= sh_split;
            o_cfg_pending <= 1'b0;
        end
    end

    // ---------------- S1: register ----------------
    // The background choice is made here, so split/bg changes line up with the
    // same input pixel as mask changes.
    logic [9:0]               s1_hpos, s1_vpos;
    logic                     s1_hsync, s1_vsync, s1_visible;
    logic [NUM_LAYERS-1:0]    s1_en;
    logic [NUM_LAYERS*CW-1:0] s1_rgb;
    logic [CW-1:0]            s1_bg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hpos    <= '0;
            s1_vpos    <= '0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            s1_visible <= 1'b0;
            s1_en      <= '0;
            s1_rgb     <= '0;
            s1_bg      <= '0;
        end else begin
            s1_hpos    <= i_hpos;
            s1_vpos    <= i_vpos;
            s1_hsync   <= i_hsync;
            s1_vsync   <= i_vsync;
            s1_visible <= i_visible;
            s1_en      <= i_layer_en & act_mask;
            s1_rgb     <= i_layer_rgb;
            s1_bg      <= (i_hpos < act_split) ? act_bg_left : act_bg_right;
        end
    end

    // ---------------- S2: select ----------------
    logic [CW-1:0] sel_rgb;
    logic          sel_found;

    always_comb begin
        sel_rgb   = s1_bg;
        sel_found = 1'b0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            if (!sel_found && s1_en[k]) begin
                sel_rgb   = s1_rgb[k*CW +: CW];
                sel_found = 1'b1;
            end
        end
        if (!s1_visible)
            sel_rgb = '0;
    end

    logic [9:0]    s2_hpos, s2_vpos;
    logic          s2_hsync, s2_vsync;
    logic [CW-1:0] s2_rgb;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_hpos  <= '0;
            s2_vpos  <= '0;
            s2_hsync <= 1'b0;
            s2_vsync <= 1'b0;
            s2_rgb   <= '0;
        end else begin
            s2_hpos  <= s1_hpos;
            s2_vpos  <= s1_vpos;
            s2_hsync <= s1_hsync;
            s2_vsync <= s1_vsync;
            s2_rgb   <= sel_rgb;
        end
    end

    // ---------------- S3: depth reduction ----------------
    logic [1:0]         bayer_val;
    logic [CH_BITS-1:0] thr, chan, shifted;
    logic [CH_BITS:0]   sum;
    logic [OW-1:0]      depth_rgb;

    always_comb begin
        case ({s2_vpos[0], s2_hpos[0]})
            2'd0:    bayer_val = 2'd0;
            2'd1:    bayer_val = 2'd2;
            2'd2:    bayer_val = 2'd3;
            default: bayer_val = 2'd1;
        endcase
        thr       = CH_BITS'(bayer_val) << TSH;
        chan      = '0;
        sum       = '0;
        shifted   = '0;
        depth_rgb = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            chan = s2_rgb[c*CH_BITS +: CH_BITS];
            sum  = {1'b0, chan};
            if (DITHER != 0) begin
                // Wide add, then clamp to full scale instead of wrapping.
                sum = {1'b0, chan} + {1'b0, thr};
                if (sum[CH_BITS])
                    sum = {1'b0, {CH_BITS{1'b1}}};
            end
            shifted = sum[CH_BITS-1:0] >> DS;
            depth_rgb[c*OUT_CH_BITS +: OUT_CH_BITS] = shifted[OUT_CH_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_rgb     <= '0;
            o_hsync_n <= 1'b1;
            o_vsync_n <= 1'b1;
            o_hpos    <= '0;
            o_vpos    <= '0;
        end else begin
            o_rgb     <= depth_rgb;
            o_hsync_n <= ~s2_hsync;
            o_vsync_n <= ~s2_vsync;
            o_hpos    <= s2_hpos;
            o_vpos    <= s2_vpos;
        end
    end

endmodule

// File: tb/tb_rbz_layer_compositor.sv
// Bench for rbz_layer_compositor: instance A (CH_BITS=2, no depth reduction)
// and instance B (CH_BITS=4 -> 2, ordered dither). Both share position, sync
// and config strobes. A reference model predicts every output cycle, and
// literal expectations placed at chosen cycles pin that model.
module tb_rbz_layer_compositor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  hpos, vpos;
    logic        hsync, vsync, visible;
    logic [3:0]  en;
    logic [5:0]  la [4];
    logic [11:0] lb [4];
    logic [23:0] rgb_a;
    logic [47:0] rgb_b;
    logic [3:0]  cfg_mask;
    logic [5:0]  cfg_bgl_a, cfg_bgr_a;
    logic [11:0] cfg_bgl_b, cfg_bgr_b;
    logic [9:0]  cfg_split;
    logic        cfg_valid, frame_end;

    logic        hsn_a, vsn_a, pend_a, hsn_b, vsn_b, pend_b;
    logic [5:0]  out_a, out_b;
    logic [9:0]  hp_a, vp_a, hp_b, vp_b;

    always_comb begin
        rgb_a = '0;
        rgb_b = '0;
        for (int k = 0; k < 4; k++) begin
            rgb_a[k*6 +: 6]   = la[k];
            rgb_b[k*12 +: 12] = lb[k];
        end
    end

    rbz_layer_compositor #(.NUM_LAYERS(4), .CH_BITS(2), .OUT_CH_BITS(2), .DITHER(0), .H_VIEW(640)) dut_a (
        .clk(clk), .reset(reset), .i_hpos(hpos), .i_vpos(vpos), .i_hsync(hsync), .i_vsync(vsync),
        .i_visible(visible), .i_layer_en(en), .i_layer_rgb(rgb_a), .i_cfg_mask(cfg_mask),
        .i_cfg_bg_left(cfg_bgl_a), .i_cfg_bg_right(cfg_bgr_a), .i_cfg_split(cfg_split),
        .i_cfg_valid(cfg_valid), .i_frame_end(frame_end), .o_hsync_n(hsn_a), .o_vsync_n(vsn_a),
        .o_rgb(out_a), .o_hpos(hp_a), .o_vpos(vp_a), .o_cfg_pending(pend_a));

    rbz_layer_compositor #(.NUM_LAYERS(4), .CH_BITS(4), .OUT_CH_BITS(2), .DITHER(1), .H_VIEW(640)) dut_b (
        .clk(clk), .reset(reset), .i_hpos(hpos), .i_vpos(vpos), .i_hsync(hsync), .i_vsync(vsync),
        .i_visible(visible), .i_layer_en(en), .i_layer_rgb(rgb_b), .i_cfg_mask(cfg_mask),
        .i_cfg_bg_left(cfg_bgl_b), .i_cfg_bg_right(cfg_bgr_b), .i_cfg_split(cfg_split),
        .i_cfg_valid(cfg_valid), .i_frame_end(frame_end), .o_hsync_n(hsn_b), .o_vsync_n(vsn_b),
        .o_rgb(out_b), .o_hpos(hp_b), .o_vpos(vp_b), .o_cfg_pending(pend_b));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [5:0] rgb;
        logic       hsn;
        logic       vsn;
        logic [9:0] hp;
        logic [9:0] vp;
    } out_t;

    localparam out_t RST_OUT = '{rgb: 6'd0, hsn: 1'b1, vsn: 1'b1, hp: 10'd0, vp: 10'd0};

    out_t        qa[$], qb[$];
    out_t        exp_a, exp_b;
    logic [3:0]  m_mask [2], s_mask [2];
    logic [11:0] m_bgl [2], m_bgr [2], s_bgl [2], s_bgr [2];
    logic [9:0]  m_split [2], s_split [2];
    logic        m_pend [2];
    int          cyc = 0;
    bit          chk_on = 0;
    int          checks = 0;
    int          errors = 0;

    // Colour the display must show for one pixel, from the active config.
    function automatic logic [5:0] model_rgb(input int inst, input logic [9:0] h, input logic [9:0] v,
                                             input logic vis, input logic [3:0] e);
        int ch, x, r;
        int bay [4];
        logic [11:0] c;
        bit found;
        bay = '{0, 2, 3, 1};
        ch = (inst == 0) ? 2 : 4;
        c = '0;
        found = 0;
        r = 0;
        if (vis) begin
            for (int k = 0; k < 4; k++) begin
                if (!found && e[k] && m_mask[inst][k]) begin
                    c = (inst == 0) ? {6'd0, la[k]} : lb[k];
                    found = 1;
                end
            end
            if (!found)
                c = (h < m_split[inst]) ? m_bgl[inst] : m_bgr[inst];
        end
        for (int i = 0; i < 3; i++) begin
            x = (int'(c) >> (i * ch)) & ((1 << ch) - 1);
            if (inst == 1) begin
                x = x + bay[2 * int'(v[0]) + int'(h[0])];
                if (x > 15) x = 15;
                x = x / 4;
            end
            r = r + x * (1 << (2 * i));
        end
        return r[5:0];
    endfunction

    initial begin
        out_t ea, eb;
        logic [11:0] in_l, in_r;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                for (int i = 0; i < 2; i++) begin
                    m_mask[i] = 4'hF;  s_mask[i] = 4'hF;
                    m_split[i] = 10'd320; s_split[i] = 10'd320;
                    m_bgl[i] = (i == 0) ? 12'h02A : 12'h888;
                    m_bgr[i] = (i == 0) ? 12'h015 : 12'h444;
                    s_bgl[i] = m_bgl[i];
                    s_bgr[i] = m_bgr[i];
                    m_pend[i] = 1'b0;
                end
                qa = '{RST_OUT, RST_OUT};
                qb = '{RST_OUT, RST_OUT};
                exp_a = RST_OUT;
                exp_b = RST_OUT;
                chk_on = 1;
            end else begin
                ea = '{rgb: model_rgb(0, hpos, vpos, visible, en), hsn: ~hsync, vsn: ~vsync, hp: hpos, vp: vpos};
                eb = '{rgb: model_rgb(1, hpos, vpos, visible, en), hsn: ~hsync, vsn: ~vsync, hp: hpos, vp: vpos};
                qa.push_back(ea);
                qb.push_back(eb);
                exp_a = qa.pop_front();
                exp_b = qb.pop_front();
                for (int i = 0; i < 2; i++) begin
                    in_l = (i == 0) ? {6'd0, cfg_bgl_a} : cfg_bgl_b;
                    in_r = (i == 0) ? {6'd0, cfg_bgr_a} : cfg_bgr_b;
                    if (cfg_valid) begin
                        s_mask[i] = cfg_mask; s_bgl[i] = in_l; s_bgr[i] = in_r; s_split[i] = cfg_split;
                        if (frame_end) begin
                            m_mask[i] = cfg_mask; m_bgl[i] = in_l; m_bgr[i] = in_r; m_split[i] = cfg_split;
                            m_pend[i] = 1'b0;
                        end else begin
                            m_pend[i] = 1'b1;
                        end
                    end else if (frame_end && m_pend[i]) begin
                        m_mask[i] = s_mask[i]; m_bgl[i] = s_bgl[i]; m_bgr[i] = s_bgr[i]; m_split[i] = s_split[i];
                        m_pend[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    typedef struct {
        int         due;
        int         fld;
        logic [15:0] val;
        bit         used;
    } lit_t;
    lit_t lits [64];

    function automatic logic [15:0] fval(input int f);
        case (f)
            0: return {10'd0, out_a};
            1: return {6'd0, hp_a};
            2: return {15'd0, pend_a};
            3: return {10'd0, out_b};
            4: return {15'd0, hsn_a};
            5: return {15'd0, vsn_a};
            default: return {15'd0, pend_b};
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            0: return "lit_a_rgb";
            1: return "lit_a_hpos";
            2: return "lit_a_pending";
            3: return "lit_b_rgb";
            4: return "lit_a_hsync_n";
            5: return "lit_a_vsync_n";
            default: return "lit_b_pending";
        endcase
    endfunction

    task automatic lit(input int delay, input int f, input logic [15:0] v);
        bit placed;
        placed = 0;
        for (int i = 0; i < 64; i++) begin
            if (!placed && !lits[i].used) begin
                lits[i] = '{due: cyc + delay, fld: f, val: v, used: 1'b1};
                placed = 1;
            end
        end
        if (!placed) begin
            errors++;
            $display("FAIL lit_table: no free slot");
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("a_rgb", {10'd0, out_a}, {10'd0, exp_a.rgb});
                chk("a_hsync_n", {15'd0, hsn_a}, {15'd0, exp_a.hsn});
                chk("a_vsync_n", {15'd0, vsn_a}, {15'd0, exp_a.vsn});
                chk("a_hpos", {6'd0, hp_a}, {6'd0, exp_a.hp});
                chk("a_vpos", {6'd0, vp_a}, {6'd0, exp_a.vp});
                chk("a_pending", {15'd0, pend_a}, {15'd0, m_pend[0]});
                chk("b_rgb", {10'd0, out_b}, {10'd0, exp_b.rgb});
                chk("b_hsync_n", {15'd0, hsn_b}, {15'd0, exp_b.hsn});
                chk("b_vsync_n", {15'd0, vsn_b}, {15'd0, exp_b.vsn});
                chk("b_hpos", {6'd0, hp_b}, {6'd0, exp_b.hp});
                chk("b_vpos", {6'd0, vp_b}, {6'd0, exp_b.vp});
                chk("b_pending", {15'd0, pend_b}, {15'd0, m_pend[1]});
            end
            for (int i = 0; i < 64; i++) begin
                if (lits[i].used && lits[i].due == cyc) begin
                    chk(fname(lits[i].fld), fval(lits[i].fld), lits[i].val);
                    lits[i].used = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic vis, input logic [3:0] e);
        hpos = h; vpos = v; visible = vis; en = e;
        hsync = h[1]; vsync = v[0];
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic set_cfg(input logic [3:0] m, input logic [9:0] s);
        cfg_mask  = m;
        cfg_split = s;
        cfg_bgl_a = 6'b101010; cfg_bgr_a = 6'b010101;
        cfg_bgl_b = 12'h888;   cfg_bgr_b = 12'h444;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) lits[i].used = 1'b0;
        for (int k = 0; k < 4; k++) begin la[k] = '0; lb[k] = '0; end
        hpos = '0; vpos = '0; hsync = 0; vsync = 0; visible = 0; en = '0;
        cfg_valid = 0; frame_end = 0;
        set_cfg(4'hF, 10'd320);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        lit(0, 0, 16'h0);
        lit(0, 4, 16'h1);
        lit(0, 2, 16'h0);

        // T1 latency and position alignment
        la[1] = 6'b110001; lb[1] = 12'hC15;
        lit(3, 0, 16'(6'b110001));
        lit(3, 1, 16'd5);
        pix(10'd5, 10'd3, 1'b1, 4'b0010);

        // T2 priority, background split, blanking
        la[2] = 6'b001110; lb[2] = 12'h3A7;
        la[0] = 6'b111111; lb[0] = 12'hFFF;
        lit(3, 0, 16'(6'b110001)); pix(10'd6, 10'd3, 1'b1, 4'b0110);
        lit(3, 0, 16'(6'b101010)); pix(10'd100, 10'd3, 1'b1, 4'b0000);
        lit(3, 0, 16'(6'b010101)); pix(10'd400, 10'd3, 1'b1, 4'b0000);
        lit(3, 0, 16'h0);          pix(10'd101, 10'd3, 1'b0, 4'b0001);

        // T3 config held in shadow until frame end
        set_cfg(4'b1101, 10'd320);
        cfg_valid = 1'b1;
        lit(1, 2, 16'h1); lit(1, 6, 16'h1);
        lit(3, 0, 16'(6'b110001)); pix(10'd200, 10'd5, 1'b1, 4'b0010);
        lit(1, 2, 16'h1);
        lit(3, 0, 16'(6'b110001)); pix(10'd201, 10'd5, 1'b1, 4'b0010);
        frame_end = 1'b1;
        lit(1, 2, 16'h0); lit(1, 6, 16'h0);
        lit(3, 0, 16'h0);          pix(10'd799, 10'd479, 1'b0, 4'b0010);
        lit(3, 0, 16'(6'b101010)); pix(10'd0, 10'd0, 1'b1, 4'b0010);
        lit(3, 0, 16'(6'b001110)); pix(10'd1, 10'd0, 1'b1, 4'b0110);

        // T4 simultaneous strobes
        set_cfg(4'b1111, 10'd200);
        cfg_valid = 1'b1; frame_end = 1'b1;
        lit(1, 2, 16'h0);
        pix(10'd799, 10'd479, 1'b0, 4'b0000);
        lit(1, 2, 16'h0);
        lit(3, 0, 16'(6'b010101)); pix(10'd250, 10'd0, 1'b1, 4'b0000);
        lit(3, 0, 16'(6'b101010)); pix(10'd150, 10'd0, 1'b1, 4'b0000);
        lit(3, 0, 16'(6'b110001)); pix(10'd2, 10'd0, 1'b1, 4'b0010);

        // T5 ordered dither on instance B
        lb[0] = 12'h600;
        lit(3, 3, 16'(6'b010000)); pix(10'd0, 10'd0, 1'b1, 4'b0001);
        lit(3, 3, 16'(6'b100000)); pix(10'd1, 10'd0, 1'b1, 4'b0001);
        lit(3, 3, 16'(6'b100000)); pix(10'd0, 10'd1, 1'b1, 4'b0001);
        lit(3, 3, 16'(6'b010000)); pix(10'd1, 10'd1, 1'b1, 4'b0001);
        lb[0] = 12'hF00;
        lit(3, 3, 16'(6'b110000)); pix(10'd0, 10'd1, 1'b1, 4'b0001);
        lb[0] = 12'h0F6;
        lit(3, 3, 16'(6'b001110)); pix(10'd1, 10'd0, 1'b1, 4'b0001);

        // T6 reset mid-frame with config pending
        set_cfg(4'b0000, 10'd320);
        cfg_valid = 1'b1;
        lit(1, 2, 16'h1);
        pix(10'd2, 10'd1, 1'b1, 4'b0001);
        pix(10'd3, 10'd1, 1'b1, 4'b0001);
        reset = 1'b1;
        lit(1, 0, 16'h0); lit(1, 4, 16'h1); lit(1, 5, 16'h1); lit(1, 2, 16'h0);
        pix(10'd2, 10'd1, 1'b1, 4'b0001);
        reset = 1'b0;
        lit(1, 2, 16'h0);
        lit(3, 0, 16'(6'b111111)); pix(10'd2, 10'd1, 1'b1, 4'b0001);
        lit(3, 0, 16'(6'b111111)); pix(10'd3, 10'd1, 1'b1, 4'b0001);

        for (int i = 0; i < 5; i++) pix(10'd0, 10'd0, 1'b0, 4'b0000);

        for (int i = 0; i < 64; i++) begin
            if (lits[i].used) begin
                errors++;
                $display("FAIL lit_expired: %s never reached (due cycle %0d)", fname(lits[i].fld), lits[i].due);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
